// File: rtl/fir_stream_adapter.sv
// AXI-Stream adapter around the FIR tap chain: feeds the head, collects the tail,
// restores tlast from a tag FIFO and bounds in-flight samples with a credit counter.
module fir_stream_adapter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DISCARD    = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [DATA_WIDTH-1:0] head_acc,
  output logic                  head_valid,
  input  logic                  head_ready,
  input  logic [DATA_WIDTH-1:0] tail_acc,
  input  logic                  tail_valid,
  output logic                  tail_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  err
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = DATA_WIDTH + 1;

  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [7:0]            disc_q, disc_d;
  logic                  err_q, err_d;

  logic [FIFO_DEPTH-1:0] tag_mem_q;
  logic [AW-1:0]         tag_wptr_q, tag_rptr_q;
  logic [CW-1:0]         tag_cnt_q;

  logic [OW-1:0]         ofifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]         of_wptr_q, of_rptr_q;
  logic [CW-1:0]         of_cnt_q;
  logic                  out_valid_q, out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic credit_ok, tag_empty;
  logic head_hs, tail_hs, disc_hs, out_push, m_hs;
  logic stage_free, load_mem, load_push, mem_push;

  // Handshake decode and credit gating
  always_comb begin
    credit_ok  = outstanding_q < CW'(FIFO_DEPTH);
    tag_empty  = (tag_cnt_q == '0);
    head_hs    = s_axis_tvalid & head_ready & credit_ok;
    tail_hs    = tail_valid & ~tag_empty;
    disc_hs    = tail_hs & (disc_q != '0);
    out_push   = tail_hs & (disc_q == '0);
    m_hs       = out_valid_q & m_axis_tready;
    stage_free = ~out_valid_q | m_hs;
    load_mem   = stage_free & (of_cnt_q != '0);
    load_push  = stage_free & (of_cnt_q == '0) & out_push;
    mem_push   = out_push & ~load_push;
  end

  always_comb begin
    outstanding_d = outstanding_q + CW'(head_hs) - CW'(m_hs) - CW'(disc_hs);
    disc_d        = disc_q;
    if (disc_hs) disc_d = disc_q - 8'd1;
    err_d         = err_q | (tail_valid & tag_empty);
  end

  assign s_axis_tready = head_ready & credit_ok;
  assign head_valid    = s_axis_tvalid & credit_ok;
  assign head_data     = s_axis_tdata;
  assign head_acc      = '0;
  assign tail_ready    = ~tag_empty;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign err           = err_q;

  // Storage arrays carry no reset; pointers and counts qualify their contents
  always_ff @(posedge clk) begin
    if (head_hs)  tag_mem_q[tag_wptr_q]  <= s_axis_tlast;
    if (mem_push) ofifo_mem_q[of_wptr_q] <= {tag_mem_q[tag_rptr_q], tail_acc};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      outstanding_q <= '0;
      disc_q        <= 8'(DISCARD);
      err_q         <= 1'b0;
      tag_wptr_q    <= '0;
      tag_rptr_q    <= '0;
      tag_cnt_q     <= '0;
      of_wptr_q     <= '0;
      of_rptr_q     <= '0;
      of_cnt_q      <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      disc_q        <= disc_d;
      err_q         <= err_d;
      if (head_hs) tag_wptr_q <= tag_wptr_q + AW'(1);
      if (tail_hs) tag_rptr_q <= tag_rptr_q + AW'(1);
      tag_cnt_q <= tag_cnt_q + CW'(head_hs) - CW'(tail_hs);
      if (mem_push) of_wptr_q <= of_wptr_q + AW'(1);
      if (load_mem) of_rptr_q <= of_rptr_q + AW'(1);
      of_cnt_q <= of_cnt_q + CW'(mem_push) - CW'(load_mem);
      // Output register refills from the FIFO first, else straight from the tail
      if (load_mem) begin
        out_valid_q              <= 1'b1;
        {out_last_q, out_data_q} <= ofifo_mem_q[of_rptr_q];
      end else if (load_push) begin
        out_valid_q              <= 1'b1;
        {out_last_q, out_data_q} <= {tag_mem_q[tag_rptr_q], tail_acc};
      end else if (m_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fir_stream_adapter.sv
// Self-checking bench for fir_stream_adapter: DUT a (DISCARD=0) with a modelled tap
// chain and queue scoreboard, DUT b (DISCARD=2) driven directly.
`timescale 1ns/1ps
module tb_fir_stream_adapter;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed { logic last; logic [DW-1:0] data; } beat_t;
  typedef struct { int t; logic [DW-1:0] d; } pipe_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [DW-1:0] a_s_tdata, a_head_data, a_head_acc, a_tail_acc, a_m_tdata;
  logic a_s_tlast, a_s_tvalid, a_s_tready, a_head_valid, a_head_ready;
  logic a_tail_valid, a_tail_ready, a_m_tlast, a_m_tvalid, a_m_tready, a_err;
  logic [DW-1:0] b_s_tdata, b_head_data, b_head_acc, b_tail_acc, b_m_tdata;
  logic b_s_tlast, b_s_tvalid, b_s_tready, b_head_valid, b_head_ready;
  logic b_tail_valid, b_tail_ready, b_m_tlast, b_m_tvalid, b_m_tready, b_err;

  fir_stream_adapter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DISCARD(0)) u_a (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(a_s_tdata), .s_axis_tlast(a_s_tlast), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .head_data(a_head_data), .head_acc(a_head_acc), .head_valid(a_head_valid), .head_ready(a_head_ready),
    .tail_acc(a_tail_acc), .tail_valid(a_tail_valid), .tail_ready(a_tail_ready),
    .m_axis_tdata(a_m_tdata), .m_axis_tlast(a_m_tlast), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
    .err(a_err));

  fir_stream_adapter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DISCARD(2)) u_b (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(b_s_tdata), .s_axis_tlast(b_s_tlast), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .head_data(b_head_data), .head_acc(b_head_acc), .head_valid(b_head_valid), .head_ready(b_head_ready),
    .tail_acc(b_tail_acc), .tail_valid(b_tail_valid), .tail_ready(b_tail_ready),
    .m_axis_tdata(b_m_tdata), .m_axis_tlast(b_m_tlast), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .err(b_err));

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  logic          h_hs_f = 1'b0;
  logic          t_hs_f = 1'b0;
  logic [DW-1:0] h_data_f;
  beat_t in_q[$], out_q[$], src_q[$];
  int    out_stamp[$], tail_stamp[$];
  int    occ = 0, max_occ = 0, over_credit = 0, head_cnt = 0;

  int    lat_min = 3, lat_max = 3, last_t = 0;
  bit    spur = 1'b0, rand_mode = 1'b0;
  pipe_t pipe[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: handshakes are evaluated on the falling edge, where inputs and state are settled
  initial forever begin
    @(negedge clk);
    ncyc++;
    if (!rstn) begin
      h_hs_f = 1'b0; t_hs_f = 1'b0; occ = 0;
    end else begin
      h_hs_f   = a_s_tvalid && a_s_tready;
      t_hs_f   = a_tail_valid && a_tail_ready;
      h_data_f = a_s_tdata;
      if (h_hs_f) begin
        in_q.push_back({a_s_tlast, a_s_tdata});
        head_cnt++;
        if (occ >= DEPTH) over_credit++;
        occ++;
      end
      if (t_hs_f) tail_stamp.push_back(ncyc);
      if (a_m_tvalid && a_m_tready) begin
        out_q.push_back({a_m_tlast, a_m_tdata});
        out_stamp.push_back(ncyc);
        occ--;
      end
      if (occ > max_occ) max_occ = occ;
    end
  end

  // Tap chain model: in-order delay line from head to tail with random latency
  initial forever begin
    int t;
    @(posedge clk); #2;
    if (!rstn) begin
      pipe.delete(); last_t = 0; a_tail_valid = 1'b0;
    end else begin
      if (t_hs_f && pipe.size() > 0) void'(pipe.pop_front());
      if (h_hs_f) begin
        t = ncyc + $urandom_range(lat_max, lat_min);
        if (t < last_t) t = last_t;
        last_t = t;
        pipe.push_back('{t, h_data_f});
      end
      a_tail_valid = spur || (pipe.size() > 0 && ncyc >= pipe[0].t);
      a_tail_acc   = spur ? 32'hDEAD_BEEF : (pipe.size() > 0 ? pipe[0].d : '0);
    end
  end

  // Upstream source and, in random mode, back-pressure generator
  initial forever begin
    bit hold;
    @(posedge clk); #2;
    hold = a_s_tvalid && !h_hs_f;
    if (h_hs_f && src_q.size() > 0) void'(src_q.pop_front());
    if (rand_mode) begin
      a_head_ready = ($urandom % 4) != 0;
      a_m_tready   = ($urandom % 3) != 0;
    end
    if (src_q.size() == 0) a_s_tvalid = 1'b0;
    else a_s_tvalid = hold || !rand_mode || (($urandom % 4) != 0);
    if (src_q.size() > 0) {a_s_tlast, a_s_tdata} = src_q[0];
  end

  task automatic clear_queues();
    in_q.delete(); out_q.delete(); out_stamp.delete(); tail_stamp.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(3);
    @(negedge clk);
    total++; if (a_tail_ready !== 1'b0) begin bad++; $display("FAIL reset_tail_ready got=%b want=0", a_tail_ready); end
    total++; if (a_m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid got=%b want=0", a_m_tvalid); end
    total++; if (a_m_tlast !== 1'b0) begin bad++; $display("FAIL reset_m_tlast got=%b want=0", a_m_tlast); end
    total++; if (a_m_tdata !== '0) begin bad++; $display("FAIL reset_m_tdata got=%h want=0", a_m_tdata); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", a_err); end
    total++; if (a_head_acc !== '0) begin bad++; $display("FAIL reset_head_acc got=%h want=0", a_head_acc); end
    total++; if (a_head_valid !== 1'b0) begin bad++; $display("FAIL reset_head_valid got=%b want=0", a_head_valid); end
    total++; if (a_s_tready !== 1'b1) begin bad++; $display("FAIL reset_s_tready got=%b want=1", a_s_tready); end
    total++; if (b_tail_ready !== 1'b0 || b_err !== 1'b0) begin bad++; $display("FAIL reset_b got=%b%b want=00", b_tail_ready, b_err); end
    tick(1);
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic test_passthrough();
    beat_t exp_b[3];
    exp_b[0] = {1'b0, 32'h0001_0002};
    exp_b[1] = {1'b0, 32'h0003_0004};
    exp_b[2] = {1'b1, 32'h0005_0006};
    clear_queues();
    lat_min = 3; lat_max = 3;
    a_head_ready = 1'b1; a_m_tready = 1'b1;
    for (int i = 0; i < 3; i++) src_q.push_back(exp_b[i]);
    @(negedge clk);
    total++; if (a_head_data !== 32'h0001_0002) begin bad++; $display("FAIL pass_head_data got=%h want=00010002", a_head_data); end
    tick(1);
    for (int i = 0; i < 60 && out_q.size() < 3; i++) tick(1);
    total++; if (out_q.size() != 3) begin bad++; $display("FAIL pass_count got=%0d want=3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_b[i]) begin bad++; $display("FAIL pass_beat%0d got=%h want=%h", i, out_q[i], exp_b[i]); end
    end
    if (out_stamp.size() > 0 && tail_stamp.size() > 0) begin
      total++; if (out_stamp[0] != tail_stamp[0] + 1) begin bad++; $display("FAIL pass_latency got=%0d want=1", out_stamp[0] - tail_stamp[0]); end
    end
  endtask

  task automatic test_credit_stall();
    beat_t sent[6];
    int h0;
    clear_queues();
    lat_min = 2; lat_max = 2;
    a_m_tready = 1'b0; a_head_ready = 1'b1;
    h0 = head_cnt;
    for (int i = 0; i < 6; i++) begin
      sent[i] = {1'($urandom), 32'($urandom)};
      src_q.push_back(sent[i]);
    end
    tick(20);
    @(negedge clk);
    total++; if (head_cnt - h0 != 4) begin bad++; $display("FAIL stall_accepted got=%0d want=4", head_cnt - h0); end
    total++; if (a_s_tready !== 1'b0) begin bad++; $display("FAIL stall_s_tready got=%b want=0", a_s_tready); end
    tick(1);
    a_m_tready = 1'b1;
    @(negedge clk);
    total++; if (a_s_tready !== 1'b0) begin bad++; $display("FAIL stall_pop_cycle_credit got=%b want=0", a_s_tready); end
    tick(1);
    a_m_tready = 1'b0;
    tick(10);
    total++; if (head_cnt - h0 != 5) begin bad++; $display("FAIL stall_one_more got=%0d want=5", head_cnt - h0); end
    a_m_tready = 1'b1;
    for (int i = 0; i < 100 && out_q.size() < 6; i++) tick(1);
    total++; if (out_q.size() != 6) begin bad++; $display("FAIL stall_drain_count got=%0d want=6", out_q.size()); end
    for (int i = 0; i < 6 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== sent[i]) begin bad++; $display("FAIL stall_beat%0d got=%h want=%h", i, out_q[i], sent[i]); end
    end
  endtask

  task automatic test_discard();
    logic [DW-1:0] d[4];
    beat_t got[$];
    beat_t want;
    b_m_tready = 1'b0; b_head_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = 32'($urandom);
    for (int i = 0; i < 4; i++) begin
      b_s_tdata = d[i]; b_s_tlast = (i == 1); b_s_tvalid = 1'b1;
      @(negedge clk);
      total++; if (b_s_tready !== 1'b1) begin bad++; $display("FAIL disc_in%0d_ready got=%b want=1", i, b_s_tready); end
      tick(1);
    end
    b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      b_tail_acc = d[i]; b_tail_valid = 1'b1;
      @(negedge clk);
      total++; if (b_tail_ready !== 1'b1) begin bad++; $display("FAIL disc_tail%0d_ready got=%b want=1", i, b_tail_ready); end
      tick(1);
    end
    b_tail_valid = 1'b0;
    b_m_tready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (b_m_tvalid && b_m_tready) got.push_back({b_m_tlast, b_m_tdata});
    end
    tick(1);
    total++; if (got.size() != 2) begin bad++; $display("FAIL disc_count got=%0d want=2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      want = {1'b0, d[i + 2]};
      total++; if (got[i] !== want) begin bad++; $display("FAIL disc_beat%0d got=%h want=%h", i, got[i], want); end
    end
    // Four fresh samples must fit before credit runs out, proving the count returned to zero
    b_m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_s_tdata = 32'($urandom); b_s_tvalid = 1'b1;
      @(negedge clk);
      total++; if (b_s_tready !== (i < 4)) begin bad++; $display("FAIL disc_credit%0d got=%b want=%b", i, b_s_tready, (i < 4)); end
      tick(1);
    end
    b_s_tvalid = 1'b0;
  endtask

  task automatic test_random();
    beat_t sent[$];
    beat_t b;
    clear_queues();
    max_occ = 0; over_credit = 0;
    lat_min = 1; lat_max = 6;
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      b = {1'(($urandom % 5) == 0), 32'($urandom)};
      sent.push_back(b);
      src_q.push_back(b);
    end
    for (int i = 0; i < 20000 && out_q.size() < 1000; i++) tick(1);
    rand_mode = 1'b0;
    a_head_ready = 1'b1; a_m_tready = 1'b1;
    tick(2);
    total++; if (out_q.size() != 1000) begin bad++; $display("FAIL rand_count got=%0d want=1000", out_q.size()); end
    for (int i = 0; i < 1000 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== sent[i]) begin bad++; $display("FAIL rand_beat%0d got=%h want=%h", i, out_q[i], sent[i]); end
    end
    total++; if (max_occ > DEPTH) begin bad++; $display("FAIL rand_occupancy got=%0d want<=%0d", max_occ, DEPTH); end
    total++; if (over_credit != 0) begin bad++; $display("FAIL rand_over_credit got=%0d want=0", over_credit); end
  endtask

  task automatic test_spurious();
    int h0;
    clear_queues();
    lat_min = 2; lat_max = 2;
    a_m_tready = 1'b1;
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    @(negedge clk);
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL spur_err got=%b want=1", a_err); end
    total++; if (a_m_tvalid !== 1'b0) begin bad++; $display("FAIL spur_m_tvalid got=%b want=0", a_m_tvalid); end
    tick(5);
    @(negedge clk);
    total++; if (a_err !== 1'b1) begin bad++; $display("FAIL spur_err_sticky got=%b want=1", a_err); end
    total++; if (out_q.size() != 0) begin bad++; $display("FAIL spur_no_beat got=%0d want=0", out_q.size()); end
    tick(1);
    a_m_tready = 1'b0;
    h0 = head_cnt;
    for (int i = 0; i < 5; i++) src_q.push_back({1'b0, 32'($urandom)});
    tick(15);
    total++; if (head_cnt - h0 != 4) begin bad++; $display("FAIL spur_credit got=%0d want=4", head_cnt - h0); end
    a_m_tready = 1'b1;
    for (int i = 0; i < 100 && out_q.size() < 5; i++) tick(1);
    total++; if (out_q.size() != 5) begin bad++; $display("FAIL spur_drain got=%0d want=5", out_q.size()); end
  endtask

  task automatic test_reset_midstream();
    beat_t one;
    clear_queues();
    lat_min = 2; lat_max = 2;
    a_m_tready = 1'b0;
    for (int i = 0; i < 3; i++) src_q.push_back({1'b1, 32'($urandom)});
    tick(15);
    total++; if (a_m_tvalid !== 1'b1) begin bad++; $display("FAIL mid_buffered got=%b want=1", a_m_tvalid); end
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    @(negedge clk);
    total++; if (a_m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_m_tvalid got=%b want=0", a_m_tvalid); end
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b want=0", a_err); end
    total++; if (a_tail_ready !== 1'b0) begin bad++; $display("FAIL mid_tail_ready got=%b want=0", a_tail_ready); end
    tick(1);
    clear_queues();
    a_m_tready = 1'b1;
    one = {1'b1, 32'($urandom)};
    src_q.push_back(one);
    for (int i = 0; i < 50 && out_q.size() < 1; i++) tick(1);
    total++; if (out_q.size() != 1) begin bad++; $display("FAIL mid_after_count got=%0d want=1", out_q.size()); end
    else begin
      total++; if (out_q[0] !== one) begin bad++; $display("FAIL mid_after_beat got=%h want=%h", out_q[0], one); end
    end
  endtask

  initial begin
    rstn = 1'b0;
    a_s_tdata = '0; a_s_tlast = 1'b0; a_s_tvalid = 1'b0; a_head_ready = 1'b1;
    a_tail_acc = '0; a_tail_valid = 1'b0; a_m_tready = 1'b0;
    b_s_tdata = '0; b_s_tlast = 1'b0; b_s_tvalid = 1'b0; b_head_ready = 1'b1;
    b_tail_acc = '0; b_tail_valid = 1'b0; b_m_tready = 1'b0;
    test_reset();
    test_passthrough();
    test_credit_stall();
    test_discard();
    test_random();
    test_spurious();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
